// File: rtl/regfile_pkg.sv
// Shared defaults and output-stage state encoding for the register-file read port.
package regfile_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_NREGS = 8;

   // Output stage: EMPTY has no result pending, FULL holds a result in rd_data.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_reader_reg_ce.sv
// WIDTH-bit storage register with clock enable and asynchronous active-high clear.
module reg_ce #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_ce,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_ce) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule : reg_ce

// File: rtl/regfile_reader.sv
// Register file with one write port and a single-entry registered read port
// using valid/ready handshaking, write-to-read bypass and a hard-wired zero register.
module regfile_reader
   import regfile_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int NREGS = DEF_NREGS,
   localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_req,
   input  logic [AW-1:0]    rd_addr,
   output logic             rd_gnt,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   input  logic             rd_ready,
   output logic             busy
);

   logic [WIDTH-1:0] w_regs [NREGS];
   logic             w_bypass;
   logic [WIDTH-1:0] w_rd_value;
   logic             w_gnt;
   logic             w_load;
   out_state_t       r_state;
   out_state_t       w_state_next;
   logic [WIDTH-1:0] r_rd_data;

   // Index 0 is a constant zero; writes aimed at it have no register to land in.
   assign w_regs[0] = '0;

   generate
      for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
         localparam logic [AW-1:0] IDX = AW'(gi);
         logic w_ce;

         assign w_ce = we && (waddr == IDX);

         reg_ce #(
            .WIDTH (WIDTH)
         ) u_reg (
            .clk  (clk),
            .rst  (rst),
            .i_ce (w_ce),
            .i_d  (wdata),
            .o_q  (w_regs[gi])
         );
      end
   endgenerate

   // A same-cycle write to the requested nonzero index forwards wdata so the
   // read observes the value the register holds after this edge.
   assign w_bypass   = we && (waddr == rd_addr) && (rd_addr != '0);
   assign w_rd_value = w_bypass ? wdata : w_regs[rd_addr];

   // Requests seen while reset is held are not granted, so none can slip through.
   assign w_gnt = rd_req && !rst && ((r_state == ST_EMPTY) || rd_ready);

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_gnt) begin
               w_state_next = ST_FULL;
               w_load       = 1'b1;
            end
         end
         ST_FULL: begin
            if (rd_ready) begin
               if (w_gnt) begin
                  w_load = 1'b1;
               end else begin
                  w_state_next = ST_EMPTY;
               end
            end
         end
         default: begin
            w_state_next = ST_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // rd_data only changes on a load, so it keeps its last value once consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_data <= '0;
      end else if (w_load) begin
         r_rd_data <= w_rd_value;
      end
   end

   assign rd_gnt   = w_gnt;
   assign rd_valid = (r_state == ST_FULL);
   assign rd_data  = r_rd_data;
   assign busy     = (r_state == ST_FULL) && !rd_ready;

endmodule : regfile_reader
